// File: rtl/tns_pkg.sv
// rtl/tns_pkg.sv - shared constants, forbidden patterns and state type for the TNS frame decoder
package tns_pkg;

    // Default codeword bit weights and group width
    localparam int TNS_W_A    = 4;
    localparam int TNS_W_B    = 2;
    localparam int TNS_W_C    = 1;
    localparam int TNS_BLEN   = 3;
    localparam int TNS_NGROUP = 4;

    // Codewords that violate the 3C crosstalk rule
    localparam logic [2:0] TNS_FORBID_A = 3'b010;
    localparam logic [2:0] TNS_FORBID_B = 3'b101;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } tns_state_e;

    function automatic logic tns_is_forbidden(input logic [2:0] code);
        return (code == TNS_FORBID_A) || (code == TNS_FORBID_B);
    endfunction

endpackage

// File: rtl/tns_frame_dec_if.sv
// rtl/tns_frame_dec_if.sv - codeword input and frame output handshake bundle
interface tns_frame_dec_if
    import tns_pkg::*;
#(
    parameter int BLEN   = TNS_BLEN,
    parameter int NGROUP = TNS_NGROUP
);
    logic                     in_valid;
    logic                     in_ready;
    logic [2:0]               in_code;
    logic                     flush;
    logic                     out_valid;
    logic                     out_ready;
    logic [NGROUP*BLEN-1:0]   out_data;
    logic                     out_err;

    // Source/sink side
    modport master (
        output in_valid, in_code, flush, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    // Decoder side
    modport slave (
        input  in_valid, in_code, flush, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/tns_group_dec.sv
// rtl/tns_group_dec.sv - combinational weighted-sum decoder for one 3-bit TNS codeword
module tns_group_dec
    import tns_pkg::*;
#(
    parameter int W_A  = TNS_W_A,
    parameter int W_B  = TNS_W_B,
    parameter int W_C  = TNS_W_C,
    parameter int BLEN = TNS_BLEN
) (
    input  logic [2:0]      i_code,
    output logic [BLEN-1:0] o_value
);

    // Sum of the weights of the set bits, kept modulo 2**BLEN
    always_comb begin
        o_value = (i_code[2] ? BLEN'(W_A) : '0)
                + (i_code[1] ? BLEN'(W_B) : '0)
                + (i_code[0] ? BLEN'(W_C) : '0);
    end

endmodule

// File: rtl/tns_frame_dec.sv
// rtl/tns_frame_dec.sv - TNS frame sequencer, one shared group decoder; optional check under TNS_DEC_CHECK_EN
module tns_frame_dec
    import tns_pkg::*;
#(
    parameter int W_A    = TNS_W_A,
    parameter int W_B    = TNS_W_B,
    parameter int W_C    = TNS_W_C,
    parameter int BLEN   = TNS_BLEN,
    parameter int NGROUP = TNS_NGROUP
) (
    input  logic           clk,
    input  logic           rst,
    tns_frame_dec_if.slave bus
);

    localparam int CW = $clog2(NGROUP);

    tns_state_e             r_state;
    tns_state_e             w_state_nxt;
    logic [CW-1:0]          r_cnt;
    logic [NGROUP*BLEN-1:0] r_data;
    logic [BLEN-1:0]        w_value;
    logic                   w_accept;
    logic                   w_last;
    logic                   w_drain;
    logic                   w_in_ready;
    logic                   w_out_valid;

    tns_group_dec #(
        .W_A  (W_A),
        .W_B  (W_B),
        .W_C  (W_C),
        .BLEN (BLEN)
    ) u_group_dec (
        .i_code  (bus.in_code),
        .o_value (w_value)
    );

    // flush beats a simultaneous codeword; nothing is taken while holding
    assign w_accept = bus.in_valid && (r_state == COLLECT) && !bus.flush;
    assign w_last   = (r_cnt == CW'(NGROUP - 1));
    assign w_drain  = (r_state == HOLD) && bus.out_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake outputs, derived from the registered state only
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            COLLECT: begin
                w_in_ready = 1'b1;
                if (w_accept && w_last) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                w_out_valid = 1'b1;
                if (w_drain) begin
                    w_state_nxt = COLLECT;
                end
            end
            default: begin
                w_state_nxt = COLLECT;
            end
        endcase
    end

    // Group counter and frame packing; first group lands in the MSB slice
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_data <= '0;
        end else if (r_state == COLLECT) begin
            if (bus.flush) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                for (int g = 0; g < NGROUP; g++) begin
                    if (r_cnt == CW'(g)) begin
                        r_data[(NGROUP-1-g)*BLEN +: BLEN] <= w_value;
                    end
                end
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_data;

`ifdef TNS_DEC_CHECK_EN
    logic r_err;
    logic w_forbidden;

    assign w_forbidden = tns_is_forbidden(bus.in_code);

    // Sticky per-frame flag; cleared when the frame leaves or the partial frame is flushed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_drain) begin
            r_err <= 1'b0;
        end else if (r_state == COLLECT) begin
            if (bus.flush) begin
                r_err <= 1'b0;
            end else if (w_accept && w_forbidden) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.out_err = r_err;
`else
    assign bus.out_err = 1'b0;
`endif

endmodule
